phv_assembler: RTL and testbench

- Sits directly downstream of the sub-parser stage. Consumes its serial extracted-value stream (value, type, seq) and writes each value into typed PHV containers.
- On an end-of-header marker, emits one complete PHV plus metadata to the match-action pipeline with valid/ready handshake.
- Double-buffered: a working container bank plus an output register, so collection of packet N+1 overlaps presentation of packet N.

---
 rtl/phv_assembler_pkg.sv | 40 ++++
 rtl/phv_assembler_cont_bank.sv | 53 +++++
 rtl/phv_assembler.sv | 139 +++++++++++++
 tb/tb_phv_assembler.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/phv_assembler_pkg.sv
// Shared definitions for the PHV assembler: container geometry, PHV field
// offsets, extracted-value type codes and the assembler state encoding.
package phv_assembler_pkg;

    localparam int VAL_IN_LEN = 48;
    localparam int NUM_CONT   = 8;
    localparam int META_LEN   = 256;

    // Container widths per type.
    localparam int W_2B = 16;
    localparam int W_4B = 32;
    localparam int W_6B = 48;

    // Working bank is every container concatenated; the PHV is bank + meta.
    localparam int BANK_LEN = NUM_CONT * (W_2B + W_4B + W_6B);
    localparam int PHV_LEN  = BANK_LEN + META_LEN;

    // Field LSB offsets inside phv_out.
    localparam int OFF_META = 0;
    localparam int OFF_2B   = OFF_META + META_LEN;
    localparam int OFF_4B   = OFF_2B + NUM_CONT * W_2B;
    localparam int OFF_6B   = OFF_4B + NUM_CONT * W_4B;

    // Extracted-value type codes.
    localparam logic [1:0] TYPE_NONE = 2'b00;
    localparam logic [1:0] TYPE_2B   = 2'b01;
    localparam logic [1:0] TYPE_4B   = 2'b10;
    localparam logic [1:0] TYPE_6B   = 2'b11;

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } asm_state_e;

    // A value is writable only with a real type and an in-range index.
    function automatic logic slot_valid(input logic [1:0] val_type, input logic [5:0] seq);
        return (val_type != TYPE_NONE) && (seq[5:3] == 3'b000);
    endfunction

endpackage

// File: rtl/phv_assembler_cont_bank.sv
// Working container bank: 8 containers each of 2B, 4B and 6B.
// bank_view shows the stored containers with any same-cycle write already
// overlaid, so a PHV captured on the hdr_end cycle includes that write.
// Clear has priority over a write in the same cycle.
module phv_cont_bank
    import phv_assembler_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  wr_en,
    input  logic [1:0]            wr_type,
    input  logic [2:0]            wr_idx,
    input  logic [VAL_IN_LEN-1:0] wr_data,
    output logic [BANK_LEN-1:0]   bank_view
);

    logic [W_2B-1:0] c2_q [NUM_CONT];
    logic [W_4B-1:0] c4_q [NUM_CONT];
    logic [W_6B-1:0] c6_q [NUM_CONT];

    // Container storage: clear on reset or packet hand-off, else typed write.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            for (int i = 0; i < NUM_CONT; i++) begin
                c2_q[i] <= '0;
                c4_q[i] <= '0;
                c6_q[i] <= '0;
            end
        end else if (wr_en) begin
            case (wr_type)
                TYPE_2B: c2_q[wr_idx] <= wr_data[W_2B-1:0];
                TYPE_4B: c4_q[wr_idx] <= wr_data[W_4B-1:0];
                TYPE_6B: c6_q[wr_idx] <= wr_data[W_6B-1:0];
                default: ;
            endcase
        end
    end

    // Flattened bank image with the pending write forwarded into its slot.
    always_comb begin
        bank_view = '0;
        for (int i = 0; i < NUM_CONT; i++) begin
            bank_view[OFF_2B - META_LEN + W_2B*i +: W_2B] =
                (wr_en && wr_type == TYPE_2B && wr_idx == 3'(i)) ? wr_data[W_2B-1:0] : c2_q[i];
            bank_view[OFF_4B - META_LEN + W_4B*i +: W_4B] =
                (wr_en && wr_type == TYPE_4B && wr_idx == 3'(i)) ? wr_data[W_4B-1:0] : c4_q[i];
            bank_view[OFF_6B - META_LEN + W_6B*i +: W_6B] =
                (wr_en && wr_type == TYPE_6B && wr_idx == 3'(i)) ? wr_data[W_6B-1:0] : c6_q[i];
        end
    end

endmodule

// File: rtl/phv_assembler.sv
// PHV assembler: collects typed extracted values into a working bank and, on
// hdr_end, hands a complete PHV + metadata to the output register.
// Handshake: a PHV transfers on a cycle where phv_out_valid && phv_out_ready;
// phv_out holds steady while valid && !ready. asm_ready is high in COLLECT;
// values or hdr_end presented while it is low are dropped.
// Optional build macro PHV_ASM_STATS_EN adds pkt_cnt and drop_cnt outputs.
module phv_assembler
    import phv_assembler_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  val_in_valid,
    input  logic [VAL_IN_LEN-1:0] val_in,
    input  logic [1:0]            val_in_type,
    input  logic [5:0]            val_in_seq,
    input  logic                  hdr_end,
    input  logic [META_LEN-1:0]   meta_in,
    output logic                  asm_ready,
    output logic                  phv_out_valid,
    output logic [PHV_LEN-1:0]    phv_out,
    input  logic                  phv_out_ready,
    output logic                  fsm_state
`ifdef PHV_ASM_STATS_EN
   ,output logic [31:0]           pkt_cnt,
    output logic [15:0]           drop_cnt
`endif
);

    asm_state_e            state_q, state_d;
    logic                  out_free;
    logic                  wr_ok;
    logic                  wr_en;
    logic                  bank_clr;
    logic                  load_out;
    logic                  load_from_in;
    logic                  meta_latch;
    logic [META_LEN-1:0]   meta_q;
    logic [BANK_LEN-1:0]   bank_view;

    assign out_free  = !phv_out_valid || phv_out_ready;
    assign asm_ready = (state_q == COLLECT);
    assign fsm_state = state_q;
    assign wr_ok     = slot_valid(val_in_type, val_in_seq);
    assign wr_en     = val_in_valid && asm_ready && wr_ok;

    phv_cont_bank u_bank (
        .clk       (clk),
        .rst       (rst),
        .clr       (bank_clr),
        .wr_en     (wr_en),
        .wr_type   (val_in_type),
        .wr_idx    (val_in_seq[2:0]),
        .wr_data   (val_in),
        .bank_view (bank_view)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= COLLECT;
        else     state_q <= state_d;
    end

    // Next state and hand-off controls.
    always_comb begin
        state_d      = state_q;
        load_out     = 1'b0;
        load_from_in = 1'b0;
        bank_clr     = 1'b0;
        meta_latch   = 1'b0;
        case (state_q)
            COLLECT: begin
                if (hdr_end) begin
                    if (out_free) begin
                        load_out     = 1'b1;
                        load_from_in = 1'b1;
                        bank_clr     = 1'b1;
                    end else begin
                        meta_latch = 1'b1;
                        state_d    = FULL;
                    end
                end
            end
            FULL: begin
                if (phv_out_ready) begin
                    load_out = 1'b1;
                    bank_clr = 1'b1;
                    state_d  = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    // Metadata of a packet parked in the bank while the output is busy.
    always_ff @(posedge clk) begin
        if (rst)             meta_q <= '0;
        else if (meta_latch) meta_q <= meta_in;
    end

    // Output register: load a new PHV or drop valid once it is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            phv_out       <= '0;
            phv_out_valid <= 1'b0;
        end else if (load_out) begin
            phv_out       <= {bank_view, (load_from_in ? meta_in : meta_q)};
            phv_out_valid <= 1'b1;
        end else if (phv_out_ready) begin
            phv_out_valid <= 1'b0;
        end
    end

`ifdef PHV_ASM_STATS_EN
    logic [1:0]  drop_now;
    logic [16:0] drop_sum;

    // Dropped events this cycle: anything offered in FULL, or an unwritable value.
    always_comb begin
        drop_now = 2'd0;
        if (state_q == FULL)
            drop_now = {1'b0, val_in_valid} + {1'b0, hdr_end};
        else if (val_in_valid && !wr_ok)
            drop_now = 2'd1;
        drop_sum = {1'b0, drop_cnt} + {15'd0, drop_now};
    end

    // Packet and saturating drop counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            if (phv_out_valid && phv_out_ready) pkt_cnt <= pkt_cnt + 32'd1;
            drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end
`endif

endmodule

// File: tb/tb_phv_assembler.sv
// Testbench for phv_assembler: directed table, hand sequences for the
// multi-cycle corners, then randomized traffic against a reference model.
module tb_phv_assembler;
    import phv_assembler_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  val_in_valid;
    logic [VAL_IN_LEN-1:0] val_in;
    logic [1:0]            val_in_type;
    logic [5:0]            val_in_seq;
    logic                  hdr_end;
    logic [META_LEN-1:0]   meta_in;
    logic                  asm_ready;
    logic                  phv_out_valid;
    logic [PHV_LEN-1:0]    phv_out;
    logic                  phv_out_ready;
    logic                  fsm_state;
`ifdef PHV_ASM_STATS_EN
    logic [31:0]           pkt_cnt;
    logic [15:0]           drop_cnt;
`endif

    phv_assembler dut (
        .clk           (clk),
        .rst           (rst),
        .val_in_valid  (val_in_valid),
        .val_in        (val_in),
        .val_in_type   (val_in_type),
        .val_in_seq    (val_in_seq),
        .hdr_end       (hdr_end),
        .meta_in       (meta_in),
        .asm_ready     (asm_ready),
        .phv_out_valid (phv_out_valid),
        .phv_out       (phv_out),
        .phv_out_ready (phv_out_ready),
        .fsm_state     (fsm_state)
`ifdef PHV_ASM_STATS_EN
       ,.pkt_cnt       (pkt_cnt),
        .drop_cnt      (drop_cnt)
`endif
    );

    // clock
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // ---------------- reference model ----------------
    // Containers indexed [type-1][seq]; a parked packet is "full".
    logic [47:0]          m_c [3][8];
    logic [META_LEN-1:0]  m_meta;
    bit                   m_full;
    bit                   m_valid;
    logic [PHV_LEN-1:0]   m_out;
    int                   m_pkt;
    int                   m_drop;
    logic [PHV_LEN-1:0]   exp_q[$];

    task automatic check(input string name, input logic [PHV_LEN-1:0] act, input logic [PHV_LEN-1:0] exp);
        int w;
        n_vec++;
        if (act !== exp) begin
            n_err++;
            w = 0;
            for (int k = 15; k >= 0; k--)
                if (act[k*64 +: 64] !== exp[k*64 +: 64]) w = k;
            $display("FAIL %s @%0t: word %0d got %h exp %h", name, $time, w, act[w*64 +: 64], exp[w*64 +: 64]);
        end
    endtask

    function automatic void model_clear();
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 8; i++) m_c[k][i] = '0;
    endfunction

    // PHV = meta | sum of containers shifted into their layout positions.
    function automatic logic [PHV_LEN-1:0] build(input logic [META_LEN-1:0] meta);
        logic [PHV_LEN-1:0] p, t;
        int wid, base;
        p = {{(PHV_LEN-META_LEN){1'b0}}, meta};
        for (int k = 0; k < 3; k++) begin
            wid  = 16 * (k + 1);
            base = 256 + ((k == 0) ? 0 : (k == 1) ? 128 : 384);
            for (int i = 0; i < 8; i++) begin
                t = {976'b0, m_c[k][i]};
                p = p | (t << (base + wid * i));
            end
        end
        return p;
    endfunction

    task automatic model_step();
        bit emit;
        logic [PHV_LEN-1:0] np;
        logic [63:0] mask;
        if (rst) begin
            model_clear();
            m_meta = '0; m_full = 0; m_valid = 0; m_out = '0;
            m_pkt = 0; m_drop = 0;
            exp_q.delete();
            return;
        end
        emit = 0;
        np = '0;
        if (m_valid && phv_out_ready) m_pkt++;
        if (!m_full) begin
            if (val_in_valid) begin
                if (val_in_type != 2'b00 && val_in_seq < 6'd8) begin
                    mask = (64'd1 << (16 * int'(val_in_type))) - 64'd1;
                    m_c[int'(val_in_type) - 1][val_in_seq[2:0]] = val_in & mask[47:0];
                end else begin
                    m_drop++;
                end
            end
            if (hdr_end) begin
                if (!m_valid || phv_out_ready) begin
                    np = build(meta_in); emit = 1; model_clear();
                end else begin
                    m_meta = meta_in; m_full = 1;
                end
            end
        end else begin
            m_drop += int'(val_in_valid) + int'(hdr_end);
            if (phv_out_ready) begin
                np = build(m_meta); emit = 1; model_clear(); m_full = 0;
            end
        end
        if (emit) begin
            m_out = np; m_valid = 1; exp_q.push_back(np);
        end else if (phv_out_ready) begin
            m_valid = 0;
        end
    endtask

    // ---------------- driver ----------------
    // One clock: score any accepted PHV, advance model, compare after the edge.
    task automatic step();
        if (rst === 1'b0 && phv_out_valid === 1'b1 && phv_out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL accept @%0t: got unexpected PHV, exp none", $time);
            end else begin
                check("accept", phv_out, exp_q.pop_front());
            end
        end
        model_step();
        @(posedge clk);
        #1;
        check("asm_ready", asm_ready, m_full ? 1'b0 : 1'b1);
        check("phv_out_valid", phv_out_valid, m_valid);
        check("phv_out", phv_out, m_out);
        check("fsm_state", fsm_state, m_full);
`ifdef PHV_ASM_STATS_EN
        check("pkt_cnt", pkt_cnt, m_pkt);
        check("drop_cnt", drop_cnt, (m_drop > 65535) ? 65535 : m_drop);
`endif
    endtask

    task automatic cycle(input logic v, input logic [1:0] t, input logic [5:0] s,
                         input logic [47:0] d, input logic he, input logic [255:0] m);
        val_in_valid = v; val_in_type = t; val_in_seq = s; val_in = d;
        hdr_end = he; meta_in = m;
        step();
    endtask

    task automatic idle();
        cycle(1'b0, 2'b00, 6'd0, 48'd0, 1'b0, 256'd0);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [1:0]  typ;
        logic [5:0]  seq;
        logic [47:0] val;
        int          lsb;
        int          wid;
        logic [47:0] exp;
    } vec_t;

    vec_t tbl[8];

    initial begin
        logic [PHV_LEN-1:0] e, sh;
        logic [63:0] wm;

        tbl[0] = '{2'b01, 6'd0, 48'h0000_0000_ABCD, 256, 16, 48'h0000_0000_ABCD};
        tbl[1] = '{2'b10, 6'd3, 48'h0000_1122_3344, 480, 32, 48'h0000_1122_3344};
        tbl[2] = '{2'b11, 6'd7, 48'hA1B2_C3D4_E5F6, 976, 48, 48'hA1B2_C3D4_E5F6};
        tbl[3] = '{2'b01, 6'd1, 48'h1234_5678_9ABC, 272, 16, 48'h0000_0000_9ABC};
        tbl[4] = '{2'b00, 6'd2, 48'h0000_0000_FFFF, 288, 16, 48'h0};
        tbl[5] = '{2'b01, 6'd9, 48'h0000_0000_7777, 272, 16, 48'h0};
        tbl[6] = '{2'b10, 6'd0, 48'h0000_CAFE_F00D, 384, 32, 48'h0000_CAFE_F00D};
        tbl[7] = '{2'b11, 6'd0, 48'h8000_0000_0001, 640, 48, 48'h8000_0000_0001};

        // reset
        rst = 1'b1; phv_out_ready = 1'b1;
        val_in_valid = 0; val_in_type = 0; val_in_seq = 0; val_in = 0; hdr_end = 0; meta_in = 0;
        step(); step();
        rst = 1'b0;
        check("rst_valid", phv_out_valid, 1'b0);
        check("rst_ready", asm_ready, 1'b1);
        check("rst_phv", phv_out, '0);
        check("rst_state", fsm_state, COLLECT);

        // table: single write then hdr_end, expect the value in its slot only
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, tbl[i].typ, tbl[i].seq, tbl[i].val, 1'b0, 256'd0);
            cycle(1'b0, 2'b00, 6'd0, 48'd0, 1'b1, 256'(i + 1));
            wm = (64'd1 << tbl[i].wid) - 64'd1;
            sh = phv_out >> tbl[i].lsb;
            check($sformatf("tbl%0d_slot", i), sh[47:0] & wm[47:0], tbl[i].exp);
            e = ({976'b0, tbl[i].exp} << tbl[i].lsb) | PHV_LEN'(i + 1);
            check($sformatf("tbl%0d_phv", i), phv_out, e);
        end

        // three containers in one packet
        cycle(1'b1, 2'b01, 6'd0, 48'hABCD, 1'b0, 256'd0);
        cycle(1'b1, 2'b10, 6'd3, 48'h1122_3344, 1'b0, 256'd0);
        cycle(1'b1, 2'b11, 6'd7, 48'hA1B2_C3D4_E5F6, 1'b0, 256'd0);
        cycle(1'b0, 2'b00, 6'd0, 48'd0, 1'b1, 256'h5A);
        e = '0;
        e[271:256]  = 16'hABCD;
        e[511:480]  = 32'h1122_3344;
        e[1023:976] = 48'hA1B2_C3D4_E5F6;
        e[255:0]    = 256'h5A;
        check("multi_phv", phv_out, e);

        // last write wins
        cycle(1'b1, 2'b01, 6'd1, 48'h1111, 1'b0, 256'd0);
        cycle(1'b1, 2'b01, 6'd1, 48'h2222, 1'b0, 256'd0);
        cycle(1'b0, 2'b00, 6'd0, 48'd0, 1'b1, 256'h7);
        check("lww", phv_out[287:272], 16'h2222);

        // write coinciding with hdr_end, then slot cleared in next packet
        cycle(1'b1, 2'b10, 6'd2, 48'hDEAD_BEEF, 1'b1, 256'h11);
        check("coinc_slot", phv_out[479:448], 32'hDEAD_BEEF);
        cycle(1'b0, 2'b00, 6'd0, 48'd0, 1'b1, 256'h12);
        check("coinc_clear", phv_out[479:448], 32'h0);
        check("coinc_phv", phv_out, PHV_LEN'(256'h12));

        // backpressure into FULL and release
        idle();
        phv_out_ready = 1'b0;
        cycle(1'b1, 2'b01, 6'd0, 48'h1, 1'b1, 256'hA1);
        check("bp_first_valid", phv_out_valid, 1'b1);
        e = '0; e[271:256] = 16'h1; e[255:0] = 256'hA1;
        cycle(1'b1, 2'b01, 6'd0, 48'h2, 1'b1, 256'hA2);
        check("bp_full_ready", asm_ready, 1'b0);
        check("bp_hold", phv_out, e);
        cycle(1'b1, 2'b10, 6'd1, 48'hBAD, 1'b1, 256'hFF);
        check("bp_stable", phv_out, e);
        check("bp_state", fsm_state, FULL);
        phv_out_ready = 1'b1;
        idle();
        e = '0; e[271:256] = 16'h2; e[255:0] = 256'hA2;
        check("bp_second", phv_out, e);
        check("bp_second_valid", phv_out_valid, 1'b1);
        check("bp_back_ready", asm_ready, 1'b1);
        idle();
        check("bp_drain_valid", phv_out_valid, 1'b0);

        // reset while FULL
        phv_out_ready = 1'b0;
        cycle(1'b0, 2'b00, 6'd0, 48'd0, 1'b1, 256'hB1);
        cycle(1'b1, 2'b10, 6'd5, 48'h55, 1'b1, 256'hB2);
        check("rf_full", asm_ready, 1'b0);
        rst = 1'b1;
        idle();
        rst = 1'b0;
        check("rf_valid", phv_out_valid, 1'b0);
        check("rf_ready", asm_ready, 1'b1);
        check("rf_phv", phv_out, '0);
        phv_out_ready = 1'b1;
        cycle(1'b0, 2'b00, 6'd0, 48'd0, 1'b1, 256'hC3);
        check("rf_bank_clear", phv_out, PHV_LEN'(256'hC3));

        // back-to-back: one PHV per cycle
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 2'($urandom_range(1, 3)), 6'($urandom_range(0, 7)),
                  {16'($urandom), 32'($urandom)}, 1'b1, 256'(i + 100));
            check("b2b_valid", phv_out_valid, 1'b1);
            check("b2b_meta", phv_out[255:0], 256'(i + 100));
        end

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst           = ($urandom_range(0, 299) == 0);
            phv_out_ready = ($urandom_range(0, 9) < 7);
            val_in_valid  = $urandom_range(0, 1);
            val_in_type   = 2'($urandom_range(0, 3));
            val_in_seq    = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(8, 63)) : 6'($urandom_range(0, 7));
            val_in        = {16'($urandom), 32'($urandom)};
            hdr_end       = ($urandom_range(0, 4) == 0);
            meta_in       = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            step();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
